// File: rtl/obliczanie_taktowania_na_stopien.sv
// Speed-to-timing converter: ticks per shaft degree = DIVIDEND / rpm.
// Free-running restoring divider, saturated to 9 bits, 0 when stopped.
module obliczanie_taktowania_na_stopien #(
  parameter int DIVIDEND   = 2520,
  parameter int DIVIDEND_W = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] rpm,
  output logic [8:0] taktowanie_na_stopien
);

  localparam int CW = $clog2(DIVIDEND_W + 1);

  localparam logic [1:0] LOAD = 2'd0;
  localparam logic [1:0] DIV  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [DIVIDEND_W-1:0] SAT = DIVIDEND_W'(511);

  logic [1:0]            state;
  logic [6:0]            d;
  logic [7:0]            r;
  logic [DIVIDEND_W-1:0] q;
  logic [CW-1:0]         cnt;

  logic [7:0]            r_sh;
  logic [DIVIDEND_W-1:0] q_sh;
  logic                  ge;

  // One restoring step: shift {R,Q} left, then test R against D.
  always_comb begin
    r_sh = {r[6:0], q[DIVIDEND_W-1]};
    q_sh = {q[DIVIDEND_W-2:0], 1'b0};
    ge   = (r_sh >= {1'b0, d});
  end

  // Sequencer: latch rpm, iterate the divider, publish the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                 <= LOAD;
      d                     <= '0;
      r                     <= '0;
      q                     <= '0;
      cnt                   <= '0;
      taktowanie_na_stopien <= '0;
    end else begin
      case (state)
        LOAD: begin
          d     <= rpm;
          r     <= '0;
          q     <= DIVIDEND_W'(DIVIDEND);
          cnt   <= CW'(DIVIDEND_W);
          state <= DIV;
        end
        DIV: begin
          r     <= ge ? (r_sh - {1'b0, d}) : r_sh;
          q     <= q_sh | {{(DIVIDEND_W-1){1'b0}}, ge};
          cnt   <= cnt - CW'(1);
          if (cnt == CW'(1))
            state <= DONE;
        end
        DONE: begin
          if (d == 7'd0)
            taktowanie_na_stopien <= 9'd0;
          else if (q > SAT)
            taktowanie_na_stopien <= 9'd511;
          else
            taktowanie_na_stopien <= q[8:0];
          state <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_obliczanie_taktowania_na_stopien.sv
// Bench for the speed-to-timing converter: scoreboard of expected
// results per pass, plus directed constants and random rpm/reset.
module tb_obliczanie_taktowania_na_stopien;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] rpm = 7'd5;
  logic [8:0] out;

  int passed = 0;
  int total  = 0;

  obliczanie_taktowania_na_stopien dut (
    .clk                   (clk),
    .rst                   (rst),
    .rpm                   (rpm),
    .taktowanie_na_stopien (out)
  );

  always #5 clk = ~clk;

  function automatic int ref_out(input int s);
    int v;
    if (s == 0) return 0;
    v = 2520 / s;
    return (v > 511) ? 511 : v;
  endfunction

  function automatic void chk(input string nm, input int act, input int exp);
    total = total + 1;
    if (act == exp) passed = passed + 1;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endfunction

  // Pass schedule: rpm sampled on the 1st edge after reset, result
  // published on the 14th, then repeating every 14 edges.
  int  e = 0;
  bit  rst_s = 1'b1;
  bit  done_edge = 1'b0;
  int  exp_q[$];

  always @(posedge clk) begin
    rst_s = rst;
    if (rst) begin
      e = 0;
      done_edge = 1'b0;
      exp_q.delete();
    end else begin
      e = e + 1;
      if ((e - 1) % 14 == 0) exp_q.push_back(ref_out(int'(rpm)));
      done_edge = (e % 14 == 0);
    end
  end

  int held = 0;

  always @(negedge clk) begin
    if (rst_s) begin
      chk("reset_out", int'(out), 0);
      held = 0;
    end else if (done_edge) begin
      if (exp_q.size() == 0) begin
        chk("done_no_expect", int'(out), -1);
      end else begin
        held = exp_q.pop_front();
        chk("done_result", int'(out), held);
      end
    end else begin
      chk("hold", int'(out), held);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_phase(input int ph);
    int k;
    k = 0;
    while ((e % 14 != ph) && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (e % 14 != ph) chk("phase_timeout", e % 14, ph);
  endtask

  int vals[5] = '{1, 4, 127, 10, 7};
  int exps[5] = '{511, 511, 19, 252, 360};

  initial begin
    rst = 1'b1;
    rpm = 7'd5;
    cyc(3);
    rst = 1'b0;
    cyc(13);
    chk("first_before", int'(out), 0);
    cyc(1);
    chk("first_504", int'(out), 504);

    rpm = 7'd0;
    cyc(100);
    chk("stopped", int'(out), 0);

    cyc(7);
    rpm = 7'd5;
    cyc(28);
    chk("step_504", int'(out), 504);
    cyc(1000);
    chk("steady_504", int'(out), 504);

    for (int i = 0; i < 5; i++) begin
      rpm = 7'(vals[i]);
      cyc(28);
      chk($sformatf("rpm%0d", vals[i]), int'(out), exps[i]);
    end

    rpm = 7'd5;
    cyc(1);
    wait_phase(1);
    cyc(5);
    rpm = 7'd10;
    wait_phase(0);
    chk("middiv_first", int'(out), 504);
    cyc(1);
    wait_phase(0);
    chk("middiv_second", int'(out), 252);

    cyc(28);
    wait_phase(5);
    rst = 1'b1;
    cyc(1);
    chk("midrst_zero", int'(out), 0);
    rst = 1'b0;
    cyc(13);
    chk("midrst_13", int'(out), 0);
    cyc(1);
    chk("midrst_14", int'(out), 252);

    for (int i = 0; i < 40; i++) begin
      rpm = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
      end
      cyc($urandom_range(1, 40));
    end
    cyc(28);
    chk("final_rand", int'(out), ref_out(int'(rpm)));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
